// File: rtl/wave_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wave_seq_pkg                                                 |
// | Description : Shared definitions for the waveform step sequencer:          |
// |               controller state encoding, switch-word field layout and the  |
// |               packed view of a step's generator configuration.             |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package wave_seq_pkg;

    // Switch word layout driven to the generator: {amp, func, freq}
    localparam int SW_W     = 13;
    localparam int FREQ_W   = 8;
    localparam int FREQ_LSB = 0;
    localparam int FUNC_W   = 3;
    localparam int FUNC_LSB = FREQ_LSB + FREQ_W;
    localparam int AMP_W    = 2;
    localparam int AMP_LSB  = FUNC_LSB + FUNC_W;

    // Controller state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_LOAD = c_ST_LOAD,
        ST_RUN  = c_ST_RUN
    } state_e;

    // Generator-facing part of a step entry; the dwell field sits above it
    // in the table word and is sized by the instantiating module.
    typedef struct packed {
        logic [AMP_W-1:0]  amp;
        logic [FUNC_W-1:0] func;
        logic [FREQ_W-1:0] freq;
    } step_cfg_t;

endpackage
`default_nettype wire

// File: rtl/wave_seq_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wave_seq_table                                               |
// | Description : STEPS x (DWELL_W+13) step table. Synchronous write port,     |
// |               asynchronous (combinational) read port, cleared by reset.    |
// | Ports       : clk, rst       - clock, async active-high reset              |
// |               wr_en/addr/data - write port                                 |
// |               rd_addr/rd_data - combinational read port                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter int STEPS   = 8,
    parameter int DWELL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [DWELL_W+SW_W-1:0]    wr_data,
    input  logic [$clog2(STEPS)-1:0]   rd_addr,
    output logic [DWELL_W+SW_W-1:0]    rd_data
);

    localparam int c_AW = $clog2(STEPS);
    localparam int c_EW = DWELL_W + SW_W;

    logic [c_EW-1:0] w_mem [STEPS];

    generate
        for (genvar g = 0; g < STEPS; g++) begin : g_entry
            logic [c_EW-1:0] r_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (wr_en && (wr_addr == c_AW'(g))) begin
                    r_q <= wr_data;
                end
            end

            assign w_mem[g] = r_q;
        end
    endgenerate

    // A read on the same edge as a write returns the pre-write contents.
    assign rd_data = w_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/wave_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wave_seq_ctrl                                                |
// | Description : Step sequencer for the waveform generator. Walks a table of  |
// |               {dwell, amp, func, freq} steps, presenting each switch word  |
// |               while holding the generator in reset for one LOAD cycle,     |
// |               then releasing it for dwell ticks.                           |
// | Ports       : clk, rst        - clock, async active-high reset             |
// |               wr_en/addr/data - step table write port                      |
// |               last_step       - index of final program step                |
// |               start, stop     - run control (stop has priority)            |
// |               tick            - dwell time base pulse                      |
// |               sw_out, gen_rst - generator switch word and reset            |
// |               step_idx, busy, done - status                                |
// | Config      : WAVE_SEQ_LOOP_EN - when defined, the program repeats until   |
// |               stop/rst instead of returning to IDLE after one pass.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wave_seq_ctrl
    import wave_seq_pkg::*;
#(
    parameter int STEPS   = 8,
    parameter int DWELL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [DWELL_W+SW_W-1:0]    wr_data,
    input  logic [$clog2(STEPS)-1:0]   last_step,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       tick,
    output logic [SW_W-1:0]           sw_out,
    output logic                       gen_rst,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int c_AW = $clog2(STEPS);
    localparam int c_EW = DWELL_W + SW_W;

    logic [1:0]         r_state;
    logic [c_AW-1:0]    r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic [SW_W-1:0]    r_sw;
    logic               r_done;

    logic               w_at_last;
    logic [c_AW-1:0]    w_rd_addr;
    logic [c_EW-1:0]    w_rd_data;
    logic [DWELL_W-1:0] w_rd_dwell;
    logic [DWELL_W-1:0] w_dwell;

    assign w_at_last = (r_idx == last_step);

    // The table is always addressed with the index the next LOAD would apply:
    // step 0 from IDLE or at program end, otherwise the following step. The
    // increment wraps naturally because STEPS is a power of two, which lets a
    // run whose index is already past a lowered last_step come back round.
    assign w_rd_addr = ((r_state == c_ST_RUN) && !w_at_last) ? (r_idx + c_AW'(1)) : '0;

    wave_seq_table #(
        .STEPS   (STEPS),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    // A zero dwell still needs one tick to leave the step.
    assign w_rd_dwell = w_rd_data[c_EW-1:SW_W];
    assign w_dwell    = (w_rd_dwell == '0) ? DWELL_W'(1) : w_rd_dwell;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_sw    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state <= c_ST_IDLE;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start) begin
                            r_state <= c_ST_LOAD;
                            r_idx   <= w_rd_addr;
                            r_sw    <= w_rd_data[SW_W-1:0];
                            r_cnt   <= w_dwell;
                        end
                    end
                    c_ST_LOAD: begin
                        r_state <= c_ST_RUN;
                    end
                    c_ST_RUN: begin
                        if (tick) begin
                            if (r_cnt > DWELL_W'(1)) begin
                                r_cnt <= r_cnt - DWELL_W'(1);
                            end else if (!w_at_last) begin
                                r_state <= c_ST_LOAD;
                                r_idx   <= w_rd_addr;
                                r_sw    <= w_rd_data[SW_W-1:0];
                                r_cnt   <= w_dwell;
                            end else begin
                                r_done <= 1'b1;
`ifdef WAVE_SEQ_LOOP_EN
                                r_state <= c_ST_LOAD;
                                r_idx   <= w_rd_addr;
                                r_sw    <= w_rd_data[SW_W-1:0];
                                r_cnt   <= w_dwell;
`else
                                r_state <= c_ST_IDLE;
`endif
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sw_out   = r_sw;
    assign gen_rst  = (r_state != c_ST_RUN);
    assign busy     = (r_state == c_ST_LOAD) || (r_state == c_ST_RUN);
    assign step_idx = r_idx;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wave_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wave_seq_ctrl                                             |
// | Description : Scoreboard bench for wave_seq_ctrl. Each run pushes the      |
// |               expected sequence of step loads (index, switch word, ticks)  |
// |               derived from a table model; a monitor pops and compares on   |
// |               every LOAD cycle and counts done pulses.                     |
// | Config      : WAVE_SEQ_LOOP_EN - selects looping expectations              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wave_seq_ctrl;

    localparam int STEPS   = 8;
    localparam int DWELL_W = 16;
    localparam int AW      = 3;
    localparam int EW      = DWELL_W + 13;
    localparam int BUDGET  = 3000;
`ifdef WAVE_SEQ_LOOP_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [EW-1:0]  wr_data;
    logic [AW-1:0]  last_step;
    logic           start;
    logic           stop;
    logic           tick;
    logic           tick_gen;
    logic           tick_man;
    logic [12:0]    sw_out;
    logic           gen_rst;
    logic [AW-1:0]  step_idx;
    logic           busy;
    logic           done;

    assign tick = tick_gen | tick_man;

    always #5 clk = ~clk;

    wave_seq_ctrl #(
        .STEPS   (STEPS),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .last_step (last_step),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .sw_out    (sw_out),
        .gen_rst   (gen_rst),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int idx;
        int sw;
        int ticks;
    } exp_t;

    exp_t          q[$];
    logic [EW-1:0] tbl [STEPS];
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            n_done    = 0;
    int            tick_mode = 0;
    bit            m_in_step = 1'b0;
    int            m_cur     = 0;
    int            m_expt    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_step(int i);
        exp_t               e;
        logic [DWELL_W-1:0] dw;
        dw      = tbl[i][EW-1:13];
        e.idx   = i;
        e.sw    = int'(tbl[i][12:0]);
        e.ticks = (dw == '0) ? 1 : int'(dw);
        q.push_back(e);
    endfunction

    // Tick source: 0 off, 1 random (about 1 in 3), 2 every fourth cycle.
    initial begin
        int cyc;
        cyc      = 0;
        tick_gen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (tick_mode)
                1:       tick_gen = ($urandom_range(0, 2) == 0);
                2:       tick_gen = ((cyc % 4) == 0);
                default: tick_gen = 1'b0;
            endcase
        end
    end

    // Monitor: LOAD is busy with generator held in reset, RUN is busy with it
    // released. Each LOAD closes the previous step's tick count.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_in_step = 1'b0;
            end else begin
                if (busy && gen_rst) begin
                    if (m_in_step) chk("step_ticks", m_cur, m_expt);
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_load: got idx %0d sw %0h expected no load", step_idx, sw_out);
                        m_in_step = 1'b0;
                    end else begin
                        e = q.pop_front();
                        chk("load_idx", step_idx, e.idx);
                        chk("load_sw", sw_out, e.sw);
                        m_expt    = e.ticks;
                        m_cur     = 0;
                        m_in_step = 1'b1;
                    end
                end else if (busy) begin
                    if (tick && m_in_step) m_cur++;
                end else begin
                    if (m_in_step && done) chk("step_ticks", m_cur, m_expt);
                    m_in_step = 1'b0;
                end
                if (done) n_done++;
            end
        end
    end

    task automatic wr_entry(int a, logic [EW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        tbl[a]  = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_run(int idx);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!(busy && !gen_rst && (int'(step_idx) == idx)) && (b < BUDGET));
        if (b >= BUDGET) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_run: got timeout expected RUN at step %0d", idx);
        end
    endtask

    task automatic finish_run(int passes, int base);
        int b;
        b = 0;
`ifdef WAVE_SEQ_LOOP_EN
        while ((n_done < base + passes) && (b < BUDGET)) begin
            @(posedge clk);
            #1;
            b++;
        end
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
`else
        while (((n_done < base + passes) || busy) && (b < BUDGET)) begin
            @(posedge clk);
            #1;
            b++;
        end
`endif
        if (b >= BUDGET) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got %0d done pulses expected %0d", n_done - base, passes);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("done_count", n_done - base, passes);
        chk("queue_empty", q.size(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_gen_rst", gen_rst, 1);
    endtask

    task automatic do_run(int passes);
        int base;
        base = n_done;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i <= int'(last_step); i++)
                push_step(i);
`ifdef WAVE_SEQ_LOOP_EN
        push_step(0);
`endif
        pulse_start();
        @(negedge clk);
        chk("load_gen_rst", gen_rst, 1);
        chk("load_busy", busy, 1);
        @(negedge clk);
        chk("run_gen_rst", gen_rst, 0);
        finish_run(passes, base);
    endtask

    initial begin
        int                 base;
        logic [DWELL_W-1:0] dw;
        logic [12:0]        sw;
        logic [EW-1:0]      new1;

        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        last_step = '0;
        start     = 1'b0;
        stop      = 1'b0;
        tick_man  = 1'b0;
        for (int i = 0; i < STEPS; i++) tbl[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sw_out", sw_out, 0);
        chk("rst_gen_rst", gen_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Empty table: one zero step lasting a single tick.
        tick_mode = 1;
        do_run(NP);

        // Two-step program, tick every fourth cycle.
        tick_mode = 0;
        wr_entry(0, {16'd3, 2'b01, 3'b000, 8'hF0});
        wr_entry(1, {16'd2, 2'b11, 3'b101, 8'hFA});
        last_step = 3'd1;
        tick_mode = 2;
        do_run(NP);

        // Random programs, including zero dwells.
        tick_mode = 1;
        repeat (6) begin
            for (int i = 0; i < STEPS; i++) begin
                dw = DWELL_W'($urandom_range(0, 4));
                sw = 13'($urandom);
                wr_entry(i, {dw, sw});
            end
            last_step = AW'($urandom_range(0, STEPS - 1));
            do_run(NP);
        end

        // Write to step 1 on the edge that loads it.
        tick_mode = 0;
        wr_entry(0, {16'd1, 13'h0123});
        wr_entry(1, {16'd1, 13'h0456});
        last_step = 3'd1;
        base = n_done;
        push_step(0);
        push_step(1);
        new1 = {16'd2, 13'h1ABC};
        pulse_start();
        wait_run(0);
        @(posedge clk);
        #1;
        tick_man = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = new1;
        @(posedge clk);
        #1;
        tick_man = 1'b0;
        wr_en    = 1'b0;
        tbl[1]   = new1;
        tick_mode = 1;
`ifdef WAVE_SEQ_LOOP_EN
        push_step(0);
        push_step(1);
        push_step(0);
        finish_run(2, base);
`else
        finish_run(1, base);
        do_run(1);
`endif

        // Stop on the same edge as the terminal tick.
        tick_mode = 0;
        wr_entry(0, {16'd1, 13'h0777});
        wr_entry(1, {16'd1, 13'h1555});
        last_step = 3'd1;
        base = n_done;
        push_step(0);
        push_step(1);
        pulse_start();
        wait_run(0);
        @(posedge clk);
        #1;
        tick_man = 1'b1;
        @(posedge clk);
        #1;
        tick_man = 1'b0;
        wait_run(1);
        @(posedge clk);
        #1;
        tick_man = 1'b1;
        stop     = 1'b1;
        @(posedge clk);
        #1;
        tick_man = 1'b0;
        stop     = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_step_idx", step_idx, 0);
        chk("stop_gen_rst", gen_rst, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stop_no_done", n_done - base, 0);
        chk("stop_queue_empty", q.size(), 0);

        // Asynchronous reset in the middle of step 1.
        wr_entry(0, {16'd1, 13'h0A5A});
        wr_entry(1, {16'd5, 13'h1F3C});
        last_step = 3'd1;
        push_step(0);
        push_step(1);
        pulse_start();
        wait_run(0);
        @(posedge clk);
        #1;
        tick_man = 1'b1;
        @(posedge clk);
        #1;
        tick_man = 1'b0;
        wait_run(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sw_out", sw_out, 0);
        chk("arst_gen_rst", gen_rst, 1);
        chk("arst_busy", busy, 0);
        chk("arst_step_idx", step_idx, 0);
        chk("arst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < STEPS; i++) tbl[i] = '0;
        chk("arst_queue_empty", q.size(), 0);

        // Table must have been cleared by the reset.
        tick_mode = 1;
        do_run(NP);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
